// File: rtl/counter_load_seq_pkg.sv
// rtl/counter_load_seq_pkg.sv - shared counter width, load hold length and FSM state encodings
package counter_load_seq_pkg;

  localparam int COUNTER_WIDTH    = 8;
  localparam int LOAD_HOLD_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/counter_load_seq_sync_edge_det.sv
// rtl/counter_load_seq_sync_edge_det.sv - input synchronizer chain with registered rise/fall pulses
module sync_edge_det
  import counter_load_seq_pkg::*;
#(
  parameter int STAGES    = 2,
  parameter bit RISE_ONLY = 1'b0,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_edge_det: STAGES must be >= 2");
  end

  assign level = chain[STAGES-1];

  // Pulses come one clock after the synchronized level changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= level;
      rise  <= level & ~prev;
      fall  <= RISE_ONLY ? 1'b0 : (~level & prev);
    end
  end

endmodule

// File: rtl/counter_load_seq.sv
// rtl/counter_load_seq.sv - serial load front end for the counter; COUNTER_LOAD_PARITY_EN adds an even parity bit
module counter_load_seq
  import counter_load_seq_pkg::*;
#(
  parameter int WIDTH       = COUNTER_WIDTH,
  parameter int HOLD_CYCLES = LOAD_HOLD_CYCLES,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_cs_n,
  input  logic             ser_clk,
  input  logic             ser_data,
  output logic [WIDTH-1:0] load_value,
  output logic             load_now,
  output logic             busy,
  output logic             frame_err
);

`ifdef COUNTER_LOAD_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  localparam int CNT_W  = $clog2(WIDTH + 2);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  // The counter needs one clock to blank its enable and one to load.
  if (HOLD_CYCLES < 2 || (HOLD_CYCLES % 2) != 0) begin : g_bad_hold
    $error("counter_load_seq: HOLD_CYCLES must be even and >= 2");
  end

  logic cs_level, cs_rise, cs_fall;
  logic sclk_level, sclk_rise, sclk_fall;
  logic data_level, data_rise, data_fall;
  logic unused_sync;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RISE_ONLY(1'b0), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .din(ser_cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RISE_ONLY(1'b1), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .din(ser_clk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RISE_ONLY(1'b1), .RESET_VAL(1'b0)) u_data_sync (
    .clk(clk), .rst_n(rst_n), .din(ser_data),
    .level(data_level), .rise(data_rise), .fall(data_fall)
  );

  assign unused_sync = ^{cs_rise, cs_fall, sclk_level, sclk_fall, data_rise, data_fall};

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [FRAME_BITS-1:0] shift;
  logic [WIDTH-1:0]      payload;
  logic                  frame_ok;

  assign payload = shift[FRAME_BITS-1 -: WIDTH];
`ifdef COUNTER_LOAD_PARITY_EN
  assign frame_ok = ((^payload) == shift[0]);
`else
  assign frame_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      hold_cnt   <= '0;
      shift      <= '0;
      load_value <= '0;
      load_now   <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!cs_level) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // A completed frame wins over a cs_n rise seen in the same clock.
          if (bit_cnt == CNT_W'(FRAME_BITS)) begin
            if (frame_ok) begin
              load_value <= payload;
              load_now   <= 1'b1;
              hold_cnt   <= HOLD_W'(HOLD_CYCLES - 1);
              state      <= ST_LOAD;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_DRAIN;
            end
          end else if (cs_level) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
            busy      <= 1'b0;
          end else if (sclk_rise) begin
            shift   <= {shift[FRAME_BITS-2:0], data_level};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_LOAD: begin
          if (hold_cnt == '0) begin
            load_now <= 1'b0;
            state    <= ST_DRAIN;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        ST_DRAIN: begin
          if (cs_level) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_load_seq.sv
// tb/tb_counter_load_seq.sv - self-checking bench for counter_load_seq (COUNTER_LOAD_PARITY_EN adds parity vectors)
module tb_counter_load_seq;
  import counter_load_seq_pkg::*;

  localparam int W    = 8;
  localparam int HOLD = 2;
  localparam int HALF = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ser_cs_n = 1'b1;
  logic         ser_clk = 1'b0;
  logic         ser_data = 1'b0;
  logic [W-1:0] load_value;
  logic         load_now, busy, frame_err;

  counter_load_seq #(.WIDTH(W), .HOLD_CYCLES(HOLD), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ser_cs_n(ser_cs_n), .ser_clk(ser_clk), .ser_data(ser_data),
    .load_value(load_value), .load_now(load_now), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic         is_load;
    logic [W-1:0] value;
  } ev_t;

  typedef struct {
    string        name;
    logic [W-1:0] value;
    int           nbits;
    int           junk;
    bit           bad_par;
  } vec_t;

  ev_t          exp_q[$];
  vec_t         vecs[$];
  logic [W-1:0] model_val = '0;
  bit           mon_en = 1'b1;
  logic         prev_ln = 1'b0;
  int           ln_len = 0;
  logic [W-1:0] ln_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic score_event(input logic is_load, input logic [W-1:0] value, input int len);
    ev_t e;
    check("event_expected", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("event_kind", 32'(is_load), 32'(e.is_load));
    check("event_value", 32'(value), 32'(e.value));
    if (is_load) check("load_now_len", 32'(len), 32'(HOLD));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (load_now && prev_ln) check("load_value_stable", 32'(load_value), 32'(ln_val));
      if (load_now && !prev_ln) begin
        ln_val = load_value;
        ln_len = 1;
      end else if (load_now) begin
        ln_len++;
      end
      if (!load_now && prev_ln) score_event(1'b1, ln_val, ln_len);
      if (frame_err) score_event(1'b0, load_value, 1);
    end
    prev_ln = load_now;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ser_data = b;
    tick(HALF);
    ser_clk = 1'b1;
    tick(HALF);
    ser_clk = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] value, input int nbits, input int junk, input bit bad_par);
    ser_cs_n = 1'b0;
    tick(8);
    for (int i = W - 1; i >= W - nbits; i--) send_bit(value[i]);
    if (nbits == W) begin
`ifdef COUNTER_LOAD_PARITY_EN
      send_bit((^value) ^ bad_par);
`endif
      for (int j = 0; j < junk; j++) send_bit(1'b1);
    end
    tick(HALF);
    ser_cs_n = 1'b1;
    tick(20);
  endtask

  task automatic run_vec(input vec_t v);
    ev_t e;
    bit  err;
    err       = (v.nbits < W) || v.bad_par;
    e.is_load = !err;
    e.value   = err ? model_val : v.value;
    exp_q.push_back(e);
    if (!err) model_val = v.value;
    send_frame(v.value, v.nbits, v.junk, v.bad_par);
    check({v.name, "_events_done"}, 32'(exp_q.size()), 32'd0);
    check({v.name, "_load_value"}, 32'(load_value), 32'(model_val));
    check({v.name, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vecs.push_back('{"nominal_a5", 8'hA5, 8, 0, 1'b0});
    vecs.push_back('{"short_5",    8'h13, 5, 0, 1'b0});
    vecs.push_back('{"extra_3c",   8'h3C, 8, 2, 1'b0});
    vecs.push_back('{"short_0",    8'h00, 0, 0, 1'b0});
    vecs.push_back('{"short_7",    8'hFF, 7, 0, 1'b0});
    vecs.push_back('{"all_ones",   8'hFF, 8, 0, 1'b0});
    vecs.push_back('{"all_zero",   8'h00, 8, 0, 1'b0});
`ifdef COUNTER_LOAD_PARITY_EN
    vecs.push_back('{"par_good_a5", 8'hA5, 8, 0, 1'b0});
    vecs.push_back('{"par_bad_a5",  8'hA5, 8, 0, 1'b1});
`endif

    tick(2);
    check("rst_load_value", 32'(load_value), 32'd0);
    check("rst_load_now", 32'(load_now), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    tick(10);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_load_now", 32'(load_now), 32'd0);

    foreach (vecs[k]) run_vec(vecs[k]);

    // Reset on the first load_now clock, held until the sender finishes.
    mon_en = 1'b0;
    fork
      send_frame(8'h5A, W, 0, 1'b0);
      begin
        for (int i = 0; i < 400 && !load_now; i++) @(negedge clk);
        check("midload_seen", 32'(load_now), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midload_load_now", 32'(load_now), 32'd0);
        check("midload_load_value", 32'(load_value), 32'd0);
        check("midload_busy", 32'(busy), 32'd0);
      end
    join
    model_val = '0;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    mon_en = 1'b1;
    check("post_rst_load_value", 32'(load_value), 32'd0);
    run_vec('{"after_reset_01", 8'h01, 8, 0, 1'b0});

    tick(10);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
